// File: rtl/ring_monitor.sv
// ring_monitor: tracks a 5-bit rotating ring, reports phase/population/health.
// Optional RING_MON_ERRCNT_EN adds a saturating rotation-error counter.
module ring_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             resync,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic [2:0]       pos,
  output logic [2:0]       pop,
  output logic             locked,
  output logic             step_ok,
  output logic             rev_tick,
  output logic [CNT_W-1:0] rev_cnt,
  output logic             rot_err,
`ifdef RING_MON_ERRCNT_EN
  output logic             err,
  output logic [3:0]       err_cnt
`else
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t     state, state_d;
  logic [4:0] s;
  logic [4:0] ref_pat;
  logic [4:0] prev;
  logic [4:0] rot_prev;
  logic [2:0] step_cnt;
  logic [2:0] s_lo;
  logic [2:0] s_pop;
  logic       is_step;
  logic       is_stall;
  logic       bad;

  // bit index: a=0 .. e=4
  assign s        = {e, d, c, b, a};
  assign rot_prev = {prev[0], prev[4:1]};
  assign is_step  = (s == rot_prev);
  assign is_stall = (s == prev);
  assign bad      = !is_step && !is_stall;

  always_comb begin
    s_lo  = 3'd7;
    s_pop = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (s[i]) s_lo = 3'(i);
    for (int i = 0; i < 5; i++)
      s_pop = s_pop + {2'b00, s[i]};
  end

  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (resync) begin
      state_d = ST_IDLE;
    end else if (en) begin
      unique case (state)
        ST_IDLE:  if (s != 5'd0) state_d = ST_TRACK;
        ST_TRACK: if (bad) state_d = ST_ERROR;
        default:  state_d = state;
      endcase
    end
  end

  always_comb begin
    locked = (state == ST_TRACK);
    err    = (state == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      pos      <= 3'd7;
      pop      <= 3'd0;
      step_ok  <= 1'b0;
      rev_tick <= 1'b0;
      rot_err  <= 1'b0;
      rev_cnt  <= '0;
      ref_pat  <= 5'd0;
      prev     <= 5'd0;
      step_cnt <= 3'd0;
    end else begin
      step_ok  <= 1'b0;
      rev_tick <= 1'b0;
      rot_err  <= 1'b0;
      if (resync) begin
        step_cnt <= 3'd0;
        ref_pat  <= 5'd0;
      end else if (en) begin
        unique case (state)
          ST_IDLE: begin
            pos <= s_lo;
            pop <= s_pop;
            if (s != 5'd0) begin
              ref_pat  <= s;
              prev     <= s;
              step_cnt <= 3'd0;
            end
          end
          ST_TRACK: begin
            if (is_step) begin
              step_ok <= 1'b1;
              prev    <= s;
              pos     <= s_lo;
              pop     <= s_pop;
              // fifth step from the reference closes a revolution
              if (step_cnt == 3'd4 && s == ref_pat) begin
                step_cnt <= 3'd0;
                rev_tick <= 1'b1;
                rev_cnt  <= rev_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
              end else begin
                step_cnt <= step_cnt + 3'd1;
              end
            end else if (bad) begin
              rot_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RING_MON_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (clear)
      err_cnt <= 4'd0;
    else if (!resync && en && state == ST_TRACK && bad && err_cnt != 4'd15)
      err_cnt <= err_cnt + 4'd1;
  end
`endif

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor: directed scenarios plus random traffic vs a
// behavioural ring model; runs CNT_W=8 and CNT_W=2 instances side by side.
module tb_ring_monitor;

  logic clk = 1'b0;
  logic clear, en, resync;
  logic a, b, c, d, e;

  logic [2:0] pos8, pop8, pos2, pop2;
  logic       locked8, step8, tick8, rerr8, err8;
  logic       locked2, step2, tick2, rerr2, err2;
  logic [7:0] rev8;
  logic [1:0] rev2;
`ifdef RING_MON_ERRCNT_EN
  logic [3:0] ecnt8, ecnt2;
`endif

  always #5 clk = ~clk;

  ring_monitor #(.CNT_W(8)) u8 (
    .clk(clk), .clear(clear), .en(en), .resync(resync),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .pos(pos8), .pop(pop8), .locked(locked8), .step_ok(step8),
    .rev_tick(tick8), .rev_cnt(rev8), .rot_err(rerr8),
`ifdef RING_MON_ERRCNT_EN
    .err(err8), .err_cnt(ecnt8)
`else
    .err(err8)
`endif
  );

  ring_monitor #(.CNT_W(2)) u2 (
    .clk(clk), .clear(clear), .en(en), .resync(resync),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .pos(pos2), .pop(pop2), .locked(locked2), .step_ok(step2),
    .rev_tick(tick2), .rev_cnt(rev2), .rot_err(rerr2),
`ifdef RING_MON_ERRCNT_EN
    .err(err2), .err_cnt(ecnt2)
`else
    .err(err2)
`endif
  );

  int passed = 0;
  int total  = 0;

  // reference model: 0 idle, 1 tracking, 2 error
  int         m_st;
  logic [4:0] m_prev;
  int         m_steps;
  int         m_revs;
  int         m_pos, m_pop;
  bit         m_step, m_tick, m_rerr;
  int         m_ecnt;

  function automatic logic [4:0] rot(input logic [4:0] p);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = p[(i + 1) % 5];
    return r;
  endfunction

  // pattern written left-to-right as a,b,c,d,e
  function automatic logic [4:0] pat(input logic [4:0] w);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = w[4 - i];
    return r;
  endfunction

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return 7;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model(input bit cl, input bit rs, input bit ev,
                       input logic [4:0] sv);
    if (cl) begin
      m_st = 0; m_prev = 0; m_steps = 0; m_revs = 0;
      m_pos = 7; m_pop = 0; m_ecnt = 0;
      m_step = 0; m_tick = 0; m_rerr = 0;
      return;
    end
    m_step = 0; m_tick = 0; m_rerr = 0;
    if (rs) begin
      m_st = 0; m_steps = 0;
    end else if (ev) begin
      if (m_st == 0) begin
        m_pos = lowest(sv); m_pop = $countones(sv);
        if (sv != 0) begin
          m_st = 1; m_prev = sv; m_steps = 0;
        end
      end else if (m_st == 1) begin
        if (sv == rot(m_prev)) begin
          m_step = 1; m_prev = sv;
          m_pos = lowest(sv); m_pop = $countones(sv);
          m_steps++;
          if (m_steps == 5) begin
            m_steps = 0; m_tick = 1; m_revs++;
          end
        end else if (sv != m_prev) begin
          m_st = 2; m_rerr = 1;
          if (m_ecnt < 15) m_ecnt++;
        end
      end
    end
  endtask

  task automatic cyc(input bit cl, input bit rs, input bit ev,
                     input logic [4:0] sv);
    @(negedge clk);
    clear = cl; resync = rs; en = ev;
    {e, d, c, b, a} = sv;
    model(cl, rs, ev, sv);
    @(posedge clk);
    #1;
    chk("pos", int'(pos8), m_pos);
    chk("pop", int'(pop8), m_pop);
    chk("locked", int'(locked8), int'(m_st == 1));
    chk("step_ok", int'(step8), int'(m_step));
    chk("rev_tick", int'(tick8), int'(m_tick));
    chk("rev_cnt8", int'(rev8), m_revs % 256);
    chk("rot_err", int'(rerr8), int'(m_rerr));
    chk("err", int'(err8), int'(m_st == 2));
    chk("rev_tick2", int'(tick2), int'(m_tick));
    chk("rev_cnt2", int'(rev2), m_revs % 4);
    chk("locked2", int'(locked2), int'(m_st == 1));
`ifdef RING_MON_ERRCNT_EN
    chk("err_cnt", int'(ecnt8), m_ecnt);
`endif
  endtask

  task automatic smp(input logic [4:0] w);
    cyc(0, 0, 1, pat(w));
  endtask

  logic [4:0] sv;
  int         r;

  initial begin
    clear = 1; resync = 0; en = 0;
    {e, d, c, b, a} = 5'd0;
    model(1, 0, 0, 5'd0);

    cyc(1, 0, 1, pat(5'b00110));
    cyc(1, 0, 1, pat(5'b00110));
    smp(5'b00000);
    chk("idle_zero_pos", int'(pos8), 7);

    smp(5'b00110);
    smp(5'b01100);
    smp(5'b11000);
    smp(5'b10001);
    smp(5'b00011);
    smp(5'b00110);
    chk("rev_after_one", int'(rev8), 1);

    cyc(0, 1, 0, 5'd0);
    smp(5'b00100);
    smp(5'b01000);
    smp(5'b01000);
    smp(5'b10000);
    chk("stall_pos", int'(pos8), 0);

    cyc(0, 1, 0, 5'd0);
    smp(5'b00110);
    smp(5'b01110);
    chk("err_pos_hold", int'(pos8), 2);
    smp(5'b01100);
    smp(5'b00000);
    cyc(0, 1, 1, pat(5'b00110));
    chk("resync_rev", int'(rev8), 1);

    // single-hot ring, 4 full revolutions
    cyc(0, 1, 0, 5'd0);
    sv = 5'b00001;
    cyc(0, 0, 1, sv);
    for (int i = 0; i < 20; i++) begin
      sv = rot(sv);
      cyc(0, 0, 1, sv);
    end
    chk("rev2_wrap", int'(rev2), 1);

    // all-hot pattern is rotation-invariant
    cyc(0, 1, 0, 5'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 5'b11111);
    cyc(0, 0, 1, 5'b00000);

    // repeated induced errors saturate the error counter
    for (int i = 0; i < 17; i++) begin
      cyc(0, 1, 0, 5'd0);
      smp(5'b00110);
      smp(5'b01110);
    end
    cyc(1, 0, 0, 5'd0);

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      sv = rot(m_prev);
      else if (r < 65) sv = m_prev;
      else             sv = 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 7), sv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
